// File: rtl/friscv_cache_blocks_ctrl.sv
// Cache block storage sequencer: read/write arbitration and flush walk.
// Optional: CACHE_CTRL_INIT_FLUSH_EN flushes all lines on reset release.
module friscv_cache_blocks_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int ILEN          = 32,
  parameter int CACHE_BLOCK_W = 128,
  parameter int CACHE_DEPTH   = 512
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       srst,
  input  logic                       flush_req,
  output logic                       flush_busy,
  output logic                       flush_done,
  input  logic                       rd1_valid,
  output logic                       rd1_ready,
  input  logic [ADDR_W-1:0]          rd1_addr,
  input  logic                       rd2_valid,
  output logic                       rd2_ready,
  input  logic [ADDR_W-1:0]          rd2_addr,
  input  logic                       wr1_valid,
  output logic                       wr1_ready,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [CACHE_BLOCK_W/8-1:0] wr1_wstrb,
  input  logic                       wr2_valid,
  output logic                       wr2_ready,
  output logic                       blk_p1_ren,
  output logic                       blk_p2_ren,
  output logic                       blk_p1_wen,
  output logic                       blk_p2_wen,
  output logic [ADDR_W-1:0]          blk_p1_waddr,
  output logic [CACHE_BLOCK_W/8-1:0] blk_p1_wstrb,
  output logic                       blk_flush
);

  localparam int INDEX_W  = $clog2(CACHE_DEPTH);
  localparam int INDEX_IX = 2 + $clog2(CACHE_BLOCK_W/ILEN);
  localparam logic [INDEX_W-1:0] LAST_IX = INDEX_W'(CACHE_DEPTH-1);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DONE
  } state_t;

`ifdef CACHE_CTRL_INIT_FLUSH_EN
  localparam state_t RST_STATE = FLUSH;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t               state_q, state_d;
  logic [INDEX_W-1:0]   cnt_q, cnt_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;

  logic                 active;
  logic                 idle;
  logic                 flushing;
  logic [INDEX_W-1:0]   rd1_idx, rd2_idx, wr1_idx;
  logic                 rd1_ok, rd2_ok;
  logic                 rd1_gnt, rd2_gnt;
  logic                 wr1_gnt, wr2_gnt;
  logic                 unused_addr;

  assign active   = aresetn & ~srst;
  assign idle     = active & (state_q == IDLE);
  assign flushing = active & (state_q == FLUSH);

  assign rd1_idx = rd1_addr[INDEX_IX +: INDEX_W];
  assign rd2_idx = rd2_addr[INDEX_IX +: INDEX_W];
  assign wr1_idx = wr1_addr[INDEX_IX +: INDEX_W];

  assign unused_addr = ^{rd1_addr, rd2_addr};

  // Round-robin grants; a read colliding with the granted write index waits
  always_comb begin
    wr1_gnt = idle & wr1_valid & (~wr2_valid | ~wr_ptr_q);
    wr2_gnt = idle & wr2_valid & (~wr1_valid |  wr_ptr_q);
    rd1_ok  = rd1_valid & ~(wr1_gnt & (rd1_idx == wr1_idx));
    rd2_ok  = rd2_valid & ~(wr1_gnt & (rd2_idx == wr1_idx));
    rd1_gnt = idle & rd1_ok & (~rd2_ok | ~rd_ptr_q);
    rd2_gnt = idle & rd2_ok & (~rd1_ok |  rd_ptr_q);
  end

  // Storage enables and flush qualifiers
  always_comb begin
    rd1_ready    = rd1_gnt;
    rd2_ready    = rd2_gnt;
    wr1_ready    = wr1_gnt;
    wr2_ready    = wr2_gnt;
    blk_p1_ren   = rd1_gnt;
    blk_p2_ren   = rd2_gnt;
    blk_p1_wen   = wr1_gnt | flushing;
    blk_p2_wen   = wr2_gnt;
    blk_flush    = flushing;
    flush_busy   = flushing;
    flush_done   = active & (state_q == DONE);
    blk_p1_waddr = flushing ? (ADDR_W'(cnt_q) << INDEX_IX) : wr1_addr;
    blk_p1_wstrb = (active & ~flushing) ? wr1_wstrb : '0;
  end

  // Next-state: flush walk and round-robin pointer updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        cnt_d = cnt_q + INDEX_W'(1);
        if (cnt_q == LAST_IX) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (rd1_gnt) rd_ptr_d = 1'b1;
    if (rd2_gnt) rd_ptr_d = 1'b0;
    if (wr1_gnt) wr_ptr_d = 1'b1;
    if (wr2_gnt) wr_ptr_d = 1'b0;
  end

  // State registers with async and sync reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else if (srst) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: tb/tb_friscv_cache_blocks_ctrl.sv
// Directed bench for friscv_cache_blocks_ctrl (CACHE_DEPTH=8).
// Covers arbitration, hazard, flush walk, abort and optional init flush.
module tb_friscv_cache_blocks_ctrl;

  localparam int DEPTH = 8;

  logic        aclk = 1'b0;
  logic        aresetn, srst, flush_req;
  logic        flush_busy, flush_done;
  logic        rd1_valid, rd1_ready, rd2_valid, rd2_ready;
  logic [31:0] rd1_addr, rd2_addr;
  logic        wr1_valid, wr1_ready, wr2_valid, wr2_ready;
  logic [31:0] wr1_addr;
  logic [15:0] wr1_wstrb;
  logic        blk_p1_ren, blk_p2_ren, blk_p1_wen, blk_p2_wen;
  logic [31:0] blk_p1_waddr;
  logic [15:0] blk_p1_wstrb;
  logic        blk_flush;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  friscv_cache_blocks_ctrl #(
    .ADDR_W(32), .ILEN(32), .CACHE_BLOCK_W(128), .CACHE_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
    .rd2_valid(rd2_valid), .rd2_ready(rd2_ready), .rd2_addr(rd2_addr),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr),
    .wr1_wstrb(wr1_wstrb), .wr2_valid(wr2_valid), .wr2_ready(wr2_ready),
    .blk_p1_ren(blk_p1_ren), .blk_p2_ren(blk_p2_ren),
    .blk_p1_wen(blk_p1_wen), .blk_p2_wen(blk_p2_wen),
    .blk_p1_waddr(blk_p1_waddr), .blk_p1_wstrb(blk_p1_wstrb),
    .blk_flush(blk_flush)
  );

  typedef struct {
    logic        r1v, r2v, w1v, w2v;
    logic [31:0] r1a, r2a, w1a;
    logic        er1, er2, ew1, ew2;
  } vec_t;

  vec_t tbl[13];

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkw(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r1v, bit r2v, bit w1v, bit w2v,
                              logic [31:0] r1a, logic [31:0] r2a,
                              logic [31:0] w1a,
                              bit er1, bit er2, bit ew1, bit ew2);
    vec_t v;
    v.r1v = r1v; v.r2v = r2v; v.w1v = w1v; v.w2v = w2v;
    v.r1a = r1a; v.r2a = r2a; v.w1a = w1a;
    v.er1 = er1; v.er2 = er2; v.ew1 = ew1; v.ew2 = ew2;
    return v;
  endfunction

  task automatic next_cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_valids(logic r1, logic r2, logic w1, logic w2);
    rd1_valid = r1; rd2_valid = r2; wr1_valid = w1; wr2_valid = w2;
  endtask

  task automatic chk_all_zero(string tag);
    chk1({tag, "_rd1_ready"}, rd1_ready, 1'b0);
    chk1({tag, "_rd2_ready"}, rd2_ready, 1'b0);
    chk1({tag, "_wr1_ready"}, wr1_ready, 1'b0);
    chk1({tag, "_wr2_ready"}, wr2_ready, 1'b0);
    chkw({tag, "_blk_en"},
         32'({blk_p1_ren, blk_p2_ren, blk_p1_wen, blk_p2_wen}), 32'h0);
    chk1({tag, "_busy"}, flush_busy, 1'b0);
    chk1({tag, "_done"}, flush_done, 1'b0);
    chk1({tag, "_blk_flush"}, blk_flush, 1'b0);
    chkw({tag, "_wstrb"}, 32'(blk_p1_wstrb), 32'h0);
  endtask

  // Called at posedge+1 right after reset release; with the init flush
  // enabled the DUT walks all indices and withholds rd1 the whole time.
  task automatic after_reset();
`ifdef CACHE_CTRL_INIT_FLUSH_EN
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge aclk);
      chk1("init_busy", flush_busy, 1'b1);
      chk1("init_rd1_ready", rd1_ready, 1'b0);
      chkw("init_waddr", blk_p1_waddr, 32'(i) << 4);
      next_cyc();
    end
    @(negedge aclk);
    chk1("init_done", flush_done, 1'b1);
    chk1("init_done_rd1_ready", rd1_ready, 1'b0);
    next_cyc();
`endif
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 0, 0, 'h40, 'h80, 'h0,   1, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 'h40, 'h80, 'h0,   0, 1, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 'h40, 'h80, 'h0,   1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 'h40, 'h80, 'h0,   0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0, 'h0,  'h104, 'h100, 0, 0, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 'h0,  'h104, 'h0,  0, 1, 0, 0);
    tbl[6]  = mk(1, 0, 1, 1, 'h200, 'h0, 'h200, 1, 0, 0, 1);
    tbl[7]  = mk(1, 1, 1, 1, 'h14, 'h20, 'h10,  0, 1, 1, 0);
    tbl[8]  = mk(1, 1, 0, 1, 'h14, 'h24, 'h0,   1, 0, 0, 1);
    tbl[9]  = mk(1, 1, 1, 0, 'h70, 'h34, 'h30,  1, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 'h0,  'h0,  'h0,   0, 0, 0, 0);
    tbl[11] = mk(1, 0, 1, 0, 'h50, 'h0,  'h50,  0, 0, 1, 0);
    tbl[12] = mk(1, 0, 0, 0, 'h50, 'h0,  'h0,   1, 0, 0, 0);

    aresetn = 1'b0; srst = 1'b0; flush_req = 1'b0;
    rd1_addr = 32'h0; rd2_addr = 32'h0; wr1_addr = 32'h0;
    wr1_wstrb = 16'hA5A5;
    set_valids(1, 1, 1, 1);
    #2;
    chk_all_zero("areset");

    // First grant after reset: rd1 only
    next_cyc();
    aresetn = 1'b1;
    set_valids(1, 0, 0, 0);
    rd1_addr = 32'h40;
    after_reset();
    @(negedge aclk);
    chk1("first_rd1_ready", rd1_ready, 1'b1);
    chk1("first_p1_ren", blk_p1_ren, 1'b1);
    chk1("first_p2_ren", blk_p2_ren, 1'b0);

    // Synchronous reset gates outputs and clears pointers
    next_cyc();
    srst = 1'b1;
    set_valids(1, 1, 1, 1);
    @(negedge aclk);
    chk_all_zero("srst");
    next_cyc();
    srst = 1'b0;
    set_valids(1, 1, 0, 0);
    rd2_addr = 32'h80;
    after_reset();

    // Arbitration and hazard vectors
    for (int i = 0; i < 13; i++) begin
      set_valids(tbl[i].r1v, tbl[i].r2v, tbl[i].w1v, tbl[i].w2v);
      rd1_addr = tbl[i].r1a;
      rd2_addr = tbl[i].r2a;
      wr1_addr = tbl[i].w1a;
      @(negedge aclk);
      chkw($sformatf("vec%0d_ready", i),
           32'({rd1_ready, rd2_ready, wr1_ready, wr2_ready}),
           32'({tbl[i].er1, tbl[i].er2, tbl[i].ew1, tbl[i].ew2}));
      chkw($sformatf("vec%0d_en", i),
           32'({blk_p1_ren, blk_p2_ren, blk_p1_wen, blk_p2_wen}),
           32'({tbl[i].er1, tbl[i].er2, tbl[i].ew1, tbl[i].ew2}));
      chk1($sformatf("vec%0d_blk_flush", i), blk_flush, 1'b0);
      if (tbl[i].ew1) begin
        chkw($sformatf("vec%0d_waddr", i), blk_p1_waddr, tbl[i].w1a);
        chkw($sformatf("vec%0d_wstrb", i), 32'(blk_p1_wstrb), 32'hA5A5);
      end
      next_cyc();
    end

    // Full flush; flush_req held high must not queue a second flush
    set_valids(0, 0, 0, 0);
    flush_req = 1'b1;
    @(negedge aclk);
    chk1("freq_cycle_busy", flush_busy, 1'b0);
    next_cyc();
    set_valids(1, 1, 1, 1);
    wr1_wstrb = 16'hFFFF;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge aclk);
      chk1($sformatf("fl%0d_busy", i), flush_busy, 1'b1);
      chkw($sformatf("fl%0d_waddr", i), blk_p1_waddr, 32'(i) << 4);
      chkw($sformatf("fl%0d_wstrb", i), 32'(blk_p1_wstrb), 32'h0);
      chkw($sformatf("fl%0d_wen_flush", i),
           32'({blk_p1_wen, blk_flush, blk_p2_wen}), 32'b110);
      chkw($sformatf("fl%0d_ready", i),
           32'({rd1_ready, rd2_ready, wr1_ready, wr2_ready}), 32'h0);
      chk1($sformatf("fl%0d_done", i), flush_done, 1'b0);
      next_cyc();
    end
    flush_req = 1'b0;
    @(negedge aclk);
    chk1("fdone_pulse", flush_done, 1'b1);
    chk1("fdone_busy", flush_busy, 1'b0);
    chk1("fdone_p1_wen", blk_p1_wen, 1'b0);
    chkw("fdone_ready",
         32'({rd1_ready, rd2_ready, wr1_ready, wr2_ready}), 32'h0);
    next_cyc();
    set_valids(1, 0, 0, 0);
    rd1_addr = 32'h40;
    @(negedge aclk);
    chk1("post_flush_done", flush_done, 1'b0);
    chk1("post_flush_busy", flush_busy, 1'b0);
    chk1("post_flush_rd1", rd1_ready, 1'b1);

    // Async reset at flush index 3 aborts the walk
    next_cyc();
    set_valids(0, 0, 0, 0);
    flush_req = 1'b1;
    next_cyc();
    flush_req = 1'b0;
    next_cyc();
    next_cyc();
    next_cyc();
    set_valids(1, 1, 1, 1);
    #1;
    chkw("abort_idx3_waddr", blk_p1_waddr, 32'h30);
    chk1("abort_idx3_busy", flush_busy, 1'b1);
    aresetn = 1'b0;
    #1;
    chk_all_zero("abort");
    next_cyc();
    aresetn = 1'b1;
    set_valids(1, 0, 0, 0);
    after_reset();
    @(negedge aclk);
    chk1("abort_rd1_ready", rd1_ready, 1'b1);
    chk1("abort_busy", flush_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/friscv_cache_blocks_ctrl.md
Name: friscv_cache_blocks_ctrl

Overview:
Sequencer and arbiter in front of the two-port cache block storage (data RAM + tag/set metadata RAM, exclusive access per cycle).
- Arbitrates two read requesters and two line-fill writers onto the storage's port-1/port-2 enables, so that at most one read and at most one write are issued per cycle.
- Runs the flush sequence that walks every index and clears its set bit.
- Sits between the fetch/memfy cache controllers and the storage block.

Parameters:
ADDR_W, 32, address bus width
ILEN, 32, instruction width
CACHE_BLOCK_W, 128, cache line payload width in bits
CACHE_DEPTH, 512, number of lines; power of two, >=2

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
srst  in  1  synchronous reset, active high
flush_req  in  1  level/pulse; starts a flush when idle
flush_busy  out  1  high while flush sequence runs
flush_done  out  1  one-cycle pulse after last index cleared
rd1_valid / rd2_valid  in  1  read request from requester 1 / 2
rd1_ready / rd2_ready  out  1  read granted this cycle
rd1_addr / rd2_addr  in  ADDR_W  read address
wr1_valid / wr2_valid  in  1  line-fill request from writer 1 / 2
wr1_ready / wr2_ready  out  1  write granted this cycle
wr1_addr  in  ADDR_W  writer-1 line address
wr1_wstrb  in  CACHE_BLOCK_W/8  writer-1 byte enables
blk_p1_ren / blk_p2_ren  out  1  storage read enables
blk_p1_wen / blk_p2_wen  out  1  storage write enables
blk_p1_waddr  out  ADDR_W  port-1 write address: wr1_addr, or flush index address
blk_p1_wstrb  out  CACHE_BLOCK_W/8  port-1 strobes: wr1_wstrb, or 0 during flush
blk_flush  out  1  storage flush qualifier: metadata set bit is written as ~blk_flush

Behaviour:
- Index field: addr[INDEX_IX +: log2(CACHE_DEPTH)], with INDEX_IX = 2 + log2(CACHE_BLOCK_W/ILEN).
- Reset (aresetn low or srst high): FSM = IDLE; both round-robin pointers point to requester 1; flush counter = 0.
  - All outputs read 0: flush_busy, flush_done, all *_ready, all blk_*en, blk_flush, blk_p1_wstrb.
- Grants and enables are combinational from registered state and same-cycle valids.
  - valid&&ready is the transfer.
  - Read response = storage hit/miss one cycle after blk_pN_ren; it is not routed by this block.
- Read arbitration (IDLE only):
  - A single valid requester is granted.
  - If both are valid, the round-robin pointer picks one.
  - The pointer moves to the other requester after each grant.
  - rdN_ready drives blk_pN_ren; never more than one ren per cycle.
- Write arbitration (IDLE only): same round-robin scheme, with an independent pointer; wrN_ready drives blk_pN_wen. A read and a write may both be granted in the same cycle.
- Hazard rule: if the granted write index equals a pending read's index in the same cycle, the read is withheld (ready=0) that cycle. The write proceeds; the read is granted the next cycle at the earliest.
- FSM states IDLE, FLUSH, DONE:
  - IDLE -> FLUSH on flush_req. Write/read grants in that same cycle still complete.
  - FLUSH, one cycle per index:
    - outputs: blk_p1_wen=1, blk_flush=1, blk_p1_wstrb=0, blk_p1_waddr = counter<<INDEX_IX (other bits 0);
    - all *_ready=0 and blk_p2_wen=0;
    - flush_busy=1; the counter increments each cycle.
  - FLUSH -> DONE when the counter equals CACHE_DEPTH-1; that index is written in the same cycle. A flush therefore takes exactly CACHE_DEPTH cycles.
  - DONE: flush_done=1 for one cycle, counter cleared, busy low -> IDLE.
- flush_req while FLUSH/DONE is ignored (not queued).
- srst or aresetn mid-flush aborts to IDLE with the counter cleared; partially cleared lines stay cleared.
- blk_flush=0 outside FLUSH, so normal writes set the set bit.

Optional Feature:
CACHE_CTRL_INIT_FLUSH_EN
- Defined: on leaving reset, the FSM enters FLUSH automatically without flush_req. All grants are withheld until flush_done, so no stale metadata is ever seen.
- Undefined: after reset the FSM sits in IDLE and waits for flush_req.

Test Plan:
- Reset, then rd1_valid=1 only, rd1_addr=0x40 -> rd1_ready=1 and blk_p1_ren=1 in the same cycle; blk_p2_ren=0.
- rd1_valid=rd2_valid=1 held for 4 cycles after reset -> grants 1,2,1,2; never both ren high.
- wr1_valid=1 (addr 0x100) with rd2_valid=1 (addr 0x104, same index) -> wr1_ready=1 and rd2_ready=0 in cycle 0; rd2_ready=1 in cycle 1.
- CACHE_DEPTH=8, pulse flush_req -> flush_busy high 8 cycles.
  - blk_p1_waddr steps through 0x00,0x10,…,0x70 with wstrb=0 and blk_flush=1.
  - flush_done pulses on the 9th cycle; every valid request sees ready=0 throughout.
- aresetn asserted at flush index 3 (DEPTH=8) -> all outputs 0 immediately; after release, rd1_valid is granted on the first cycle.
- With CACHE_CTRL_INIT_FLUSH_EN, DEPTH=8, rd1_valid held from reset release -> rd1_ready stays 0 until the cycle after flush_done.
